// File: rtl/sat_sum_counter_bank_if.sv
// Readout port of sat_sum_counter_bank: a request channel (index in) and a
// response channel (captured count out), each with a valid/ready handshake.
interface sat_sum_counter_bank_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 3
) ();
  logic             req_valid;
  logic             req_ready;
  logic [CH_W-1:0]  req_ch;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_data;
  logic             rsp_err;

  // Requester side
  modport master (
    output req_valid, req_ch, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Counter bank side
  modport slave (
    input  req_valid, req_ch, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sat_sum_counter_bank.sv
// Bank of NCH up/down saturating counters, CNT_W = P + EXTRA_W bits each,
// with a two-state valid/ready readout port.
// Optional feature macro: SAT_CNT_OVF_FLAG_EN adds sticky per-channel
// overflow flags (ovf) that set on an increment attempted at MAX.
module sat_sum_counter_bank #(
  parameter int unsigned P       = 1,
  parameter int unsigned EXTRA_W = 2,
  parameter int unsigned NCH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       inc,
  input  logic [NCH-1:0]       dec,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       sat,
`ifdef SAT_CNT_OVF_FLAG_EN
  output logic [NCH-1:0]       ovf,
`endif
  sat_sum_counter_bank_if.slave bus
);

  localparam int unsigned CNT_W = P + EXTRA_W;
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] MAX = CNT_W'('1);

  // Reject parameter sets outside the supported range at elaboration
  if (P < 1 || CNT_W > 32 || NCH < 1 || NCH > 16) begin : g_param_check
    $error("sat_sum_counter_bank: unsupported parameter set");
  end

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] rd_data_c;
  logic             rd_hit_c;

  // Per-channel saturating update: clr wins, inc&dec cancel, no wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          cnt[i] <= '0;
        end else if (inc[i] && !dec[i] && cnt[i] != MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Saturation flags straight from the counter registers
  always_comb begin
    sat = '0;
    for (int unsigned i = 0; i < NCH; i++) sat[i] = (cnt[i] == MAX);
  end

  // Select the requested channel; an index past NCH-1 matches nothing
  always_comb begin
    rd_data_c = '0;
    rd_hit_c  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.req_ch == CH_W'(i)) begin
        rd_data_c = cnt[i];
        rd_hit_c  = 1'b1;
      end
    end
  end

  // Readout FSM: capture pre-update count on accept, hold until rsp_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state         <= RESP;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= rd_hit_c ? rd_data_c : '0;
            bus.rsp_err   <= !rd_hit_c;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAT_CNT_OVF_FLAG_EN
  // Sticky overflow: set on a lone increment at MAX, cleared only by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          ovf[i] <= 1'b0;
        end else if (inc[i] && !dec[i] && cnt[i] == MAX) begin
          ovf[i] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sat_sum_counter_bank.sv
// Self-checking bench: DUT A at defaults (CNT_W=3, NCH=4) checked every cycle
// against an integer model; DUT B (P=5, EXTRA_W=2, NCH=5) covers the wide
// counter and out-of-range read index cases.
module tb_sat_sum_counter_bank;

  localparam int A_NCH = 4;
  localparam int A_MAX = 7;
  localparam int B_NCH = 5;
  localparam int B_MAX = 127;

  logic clk;
  logic rst_n;
  logic [A_NCH-1:0] inc_a, dec_a, clr_a, sat_a;
  logic [B_NCH-1:0] inc_b, dec_b, clr_b, sat_b;
`ifdef SAT_CNT_OVF_FLAG_EN
  logic [A_NCH-1:0] ovf_a;
  logic [B_NCH-1:0] ovf_b;
`endif

  sat_sum_counter_bank_if #(.CH_W(2), .CNT_W(3)) bus_a ();
  sat_sum_counter_bank_if #(.CH_W(3), .CNT_W(7)) bus_b ();

  sat_sum_counter_bank #(.P(1), .EXTRA_W(2), .NCH(A_NCH)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .inc(inc_a), .dec(dec_a), .clr(clr_a), .sat(sat_a),
`ifdef SAT_CNT_OVF_FLAG_EN
    .ovf(ovf_a),
`endif
    .bus(bus_a.slave)
  );

  sat_sum_counter_bank #(.P(5), .EXTRA_W(2), .NCH(B_NCH)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .inc(inc_b), .dec(dec_b), .clr(clr_b), .sat(sat_b),
`ifdef SAT_CNT_OVF_FLAG_EN
    .ovf(ovf_b),
`endif
    .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model for DUT A: plain integers, clamped arithmetic
  int m_cnt [A_NCH];
  bit m_ovf [A_NCH];
  bit m_busy;
  int m_data;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < A_NCH; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_data = 0;
    m_err  = 1'b0;
  endtask

  // Compare every observable output of DUT A with the model
  task automatic check_a();
    logic [A_NCH-1:0] exp_sat;
    for (int i = 0; i < A_NCH; i++) exp_sat[i] = (m_cnt[i] == A_MAX);
    chk("sat_a", 32'(sat_a), 32'(exp_sat));
    chk("req_ready_a", 32'(bus_a.req_ready), 32'(!m_busy));
    chk("rsp_valid_a", 32'(bus_a.rsp_valid), 32'(m_busy));
    if (m_busy) begin
      chk("rsp_data_a", 32'(bus_a.rsp_data), 32'(m_data));
      chk("rsp_err_a", 32'(bus_a.rsp_err), 32'(m_err));
    end
`ifdef SAT_CNT_OVF_FLAG_EN
    for (int i = 0; i < A_NCH; i++) chk("ovf_a", 32'(ovf_a[i]), 32'(m_ovf[i]));
`endif
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check
  task automatic tick();
    int idx;
    int nxt;
    @(posedge clk);
    if (!m_busy) begin
      if (bus_a.req_valid) begin
        idx    = int'(bus_a.req_ch);
        m_busy = 1'b1;
        m_data = (idx < A_NCH) ? m_cnt[idx] : 0;
        m_err  = (idx >= A_NCH);
      end
    end else if (bus_a.rsp_ready) begin
      m_busy = 1'b0;
    end
    for (int i = 0; i < A_NCH; i++) begin
      if (clr_a[i]) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else begin
        if (inc_a[i] && !dec_a[i] && m_cnt[i] == A_MAX) m_ovf[i] = 1'b1;
        nxt = m_cnt[i] + int'(inc_a[i]) - int'(dec_a[i]);
        if (nxt > A_MAX) nxt = A_MAX;
        if (nxt < 0) nxt = 0;
        m_cnt[i] = nxt;
      end
    end
    #1;
    check_a();
  endtask

  // Full read of DUT A channel ch; expected value is checked explicitly
  task automatic read_a(input int ch, input int exp);
    bus_a.req_valid = 1'b1;
    bus_a.req_ch    = 2'(ch);
    tick();
    bus_a.req_valid = 1'b0;
    chk("read_a_data", 32'(bus_a.rsp_data), 32'(exp));
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic read_b(input int ch, input int exp_data, input int exp_err);
    bus_b.req_valid = 1'b1;
    bus_b.req_ch    = 3'(ch);
    tick();
    bus_b.req_valid = 1'b0;
    chk("read_b_valid", 32'(bus_b.rsp_valid), 32'd1);
    chk("read_b_data", 32'(bus_b.rsp_data), 32'(exp_data));
    chk("read_b_err", 32'(bus_b.rsp_err), 32'(exp_err));
    bus_b.rsp_ready = 1'b1;
    tick();
    bus_b.rsp_ready = 1'b0;
    chk("read_b_idle", 32'(bus_b.req_ready), 32'd1);
  endtask

  task automatic pulse_a(input logic [A_NCH-1:0] i_v, input logic [A_NCH-1:0] d_v,
                         input logic [A_NCH-1:0] c_v, input int n);
    inc_a = i_v; dec_a = d_v; clr_a = c_v;
    for (int k = 0; k < n; k++) tick();
    inc_a = '0; dec_a = '0; clr_a = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    inc_a = '0; dec_a = '0; clr_a = '0;
    inc_b = '0; dec_b = '0; clr_b = '0;
    bus_a.req_valid = 1'b0; bus_a.req_ch = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_ch = '0; bus_b.rsp_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus_a.rsp_data), 32'd0);
    chk("rst_sat", 32'(sat_a), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(bus_a.req_ready), 32'd1);

    // 1: saturate ch0 at 7, 8th increment holds
    pulse_a(4'b0001, 4'b0000, 4'b0000, 7);
    chk("t1_sat0", 32'(sat_a[0]), 32'd1);
    pulse_a(4'b0001, 4'b0000, 4'b0000, 1);
    read_a(0, 7);

    // 2: decrement at 0 holds; inc&dec together holds
    pulse_a(4'b0000, 4'b0010, 4'b0000, 1);
    read_a(1, 0);
    pulse_a(4'b0010, 4'b0000, 4'b0000, 3);
    pulse_a(4'b0010, 4'b0010, 4'b0000, 1);
    read_a(1, 3);

    // 3: ch2 overflows, returns to 5, then clr&inc clears to 0
    pulse_a(4'b0100, 4'b0000, 4'b0000, 8);
    pulse_a(4'b0000, 4'b0100, 4'b0000, 2);
    read_a(2, 5);
    pulse_a(4'b0100, 4'b0000, 4'b0100, 1);
    read_a(2, 0);

    // 4: ch3=4, response held under back-pressure for 3 cycles
    pulse_a(4'b1000, 4'b0000, 4'b0000, 4);
    bus_a.req_valid = 1'b1;
    bus_a.req_ch    = 2'd3;
    tick();
    bus_a.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_data", 32'(bus_a.rsp_data), 32'd4);
      chk("t4_hold_ready", 32'(bus_a.req_ready), 32'd0);
    end
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;
    chk("t4_back_idle", 32'(bus_a.req_ready), 32'd1);

    // Randomized traffic on DUT A against the model
    for (int k = 0; k < 600; k++) begin
      inc_a = 4'($urandom);
      dec_a = 4'($urandom);
      clr_a = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      bus_a.req_valid = ($urandom_range(0, 2) == 0);
      bus_a.req_ch    = 2'($urandom);
      bus_a.rsp_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    inc_a = '0; dec_a = '0; clr_a = '0;
    bus_a.req_valid = 1'b0;
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;

    // 5: wide counter saturates at 127; out-of-range index reports an error
    inc_b = 5'b00001;
    for (int k = 0; k < 130; k++) tick();
    inc_b = '0;
    chk("t5_sat_b", 32'(sat_b), 32'd1);
    read_b(0, B_MAX, 0);
    read_b(5, 0, 1);
    read_b(7, 0, 1);
    inc_b = 5'b10000;
    for (int k = 0; k < 3; k++) tick();
    inc_b = '0;
    read_b(4, 3, 0);

    // 6: reset in the middle of a response
    pulse_a(4'b0110, 4'b0000, 4'b0000, 2);
    bus_a.req_valid = 1'b1;
    bus_a.req_ch    = 2'd1;
    tick();
    bus_a.req_valid = 1'b0;
    chk("t6_busy", 32'(bus_a.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("t6_rst_sat_a", 32'(sat_a), 32'd0);
    chk("t6_rst_sat_b", 32'(sat_b), 32'd0);
    chk("t6_rst_rsp_data", 32'(bus_a.rsp_data), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("t6_req_ready", 32'(bus_a.req_ready), 32'd1);
    read_a(1, 0);
    read_a(2, 0);
    read_b(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
